// File: rtl/uart_rx.sv
// uart_rx: 16x oversampling serial receiver in the clock50 domain.
// Frame is 8N1 by default; define UART_RX_PARITY_EN for 8E1 (even parity bit
// between data bit 7 and the stop bit).
// Baud ticks come from a 32-bit phase accumulator whose carry-out is one oversample tick.
module uart_rx #(
    parameter logic [31:0] BAUD_INC = 32'd158329674
) (
    input  logic       clock50,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StParity   = 3'd3,
        StStop     = 3'd4,
        StWaitHigh = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
        StStop     = 3'd4,
        StWaitHigh = 3'd5
    } state_t;
`endif

    state_t      state;
    logic        rx_meta;
    logic        rxs;
    logic [31:0] acc;
    logic [32:0] acc_sum;
    logic        tick;
    logic [3:0]  scnt;
    logic [2:0]  bcnt;
    logic [7:0]  shreg;
    logic        mid_sample;
`ifdef UART_RX_PARITY_EN
    logic        par_bad;
`endif

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clock50) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign acc_sum    = {1'b0, acc} + {1'b0, BAUD_INC};
    assign tick       = acc_sum[32];
    assign mid_sample = tick && (scnt == 4'd15);
    assign busy       = (state != StIdle);

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

    // Receive FSM with tick generation, sample counting and registered strobes.
    always_ff @(posedge clock50) begin
        if (reset) begin
            state     <= StIdle;
            acc       <= 32'd0;
            scnt      <= 4'd0;
            bcnt      <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
            par_bad    <= 1'b0;
`endif
        end else begin
            acc       <= acc_sum[31:0];
            valid     <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (tick && state != StIdle) begin
                scnt <= scnt + 4'd1;
            end

            case (state)
                StIdle: begin
                    if (!rxs) begin
                        // Restart the tick phase so sampling aligns to the start edge.
                        scnt  <= 4'd0;
                        acc   <= 32'd0;
                        bcnt  <= 3'd0;
                        state <= StStart;
                    end
                end
                StStart: begin
                    if (tick && scnt == 4'd7) begin
                        if (rxs) begin
                            state <= StIdle;
                        end else begin
                            scnt  <= 4'd0;
                            state <= StData;
                        end
                    end
                end
                StData: begin
                    if (mid_sample) begin
                        shreg <= {rxs, shreg[7:1]};
                        bcnt  <= bcnt + 3'd1;
                        if (bcnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= StParity;
`else
                            state <= StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (mid_sample) begin
                        par_bad <= (rxs != ^shreg);
                        state   <= StStop;
                    end
                end
`endif
                StStop: begin
                    if (mid_sample) begin
                        if (rxs) begin
                            data <= shreg;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                valid <= 1'b1;
                            end
`else
                            valid <= 1'b1;
`endif
                            // Leaving in mid stop bit keeps back-to-back frames intact.
                            state <= StIdle;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= StWaitHigh;
                        end
                    end
                end
                StWaitHigh: begin
                    // Hold off during a break so a held-low line is not taken as a start bit.
                    if (rxs) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
